// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the two-digit BCD countdown timer.
// Holds the FSM state encoding, BCD digit limits and a digit clamp helper.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Non-BCD codes (10..15) saturate to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// Single BCD digit decrementer (combinational).
// Ports:
//   digit      in  4  current digit value (0..9)
//   dec_en     in  1  decrement this digit
//   next_digit out 4  digit after optional decrement; 0 wraps to 9
//   borrow_out out 1  high when digit is 0 and dec_en is high
module bcd_down_digit
  import bcd_countdown_timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dec_en,
  output logic [3:0] next_digit,
  output logic       borrow_out
);

  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (dec_en) begin
      if (digit == BCD_ZERO) begin
        next_digit = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with prescaled decrement, pause/resume and a
// single-cycle done pulse on expiry.
// Parameters:
//   TICK_DIV  clock cycles per decrement (1..65535)
//   PRE_W     prescaler width, must hold TICK_DIV-1
// Ports:
//   clock       in  1  system clock, rising edge
//   reset       in  1  synchronous active-high reset
//   load        in  1  capture preset digits (clamped to 9)
//   load_tens   in  4  preset tens digit
//   load_units  in  4  preset units digit
//   start       in  1  begin or resume counting
//   pause       in  1  freeze counting (beats start)
//   tens        out 4  current tens digit
//   units       out 4  current units digit
//   running     out 1  high while counting
//   done        out 1  one-cycle expiry pulse
// Optional build macro: BCD_COUNTDOWN_AUTO_RELOAD_EN -- on expiry reload the
// preset and keep running instead of stopping (a 00 preset still stops).
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned PRE_W    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       done
);
  import bcd_countdown_timer_pkg::*;

  state_t             state_q;
  logic [PRE_W-1:0]   pre_q;
  logic [3:0]         preset_tens_q;
  logic [3:0]         preset_units_q;

  logic               tick;
  logic               units_borrow;
  logic               tens_borrow;
  logic [3:0]         next_units;
  logic [3:0]         next_tens;
  logic               value_zero;
  logic               expire;

  assign tick       = (pre_q == PRE_W'(TICK_DIV - 1));
  assign value_zero = (tens == BCD_ZERO) && (units == BCD_ZERO);
  assign expire     = (next_tens == BCD_ZERO) && (next_units == BCD_ZERO);

  bcd_down_digit u_units (
    .digit      (units),
    .dec_en     (tick),
    .next_digit (next_units),
    .borrow_out (units_borrow)
  );

  bcd_down_digit u_tens (
    .digit      (tens),
    .dec_en     (units_borrow),
    .next_digit (next_tens),
    .borrow_out (tens_borrow)
  );

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  logic preset_zero;
  assign preset_zero = (preset_tens_q == BCD_ZERO) && (preset_units_q == BCD_ZERO);
  logic unused_borrow;
  assign unused_borrow = tens_borrow;
`else
  // Preset is captured but never read back without auto-reload.
  logic unused_sig;
  assign unused_sig = ^{tens_borrow, preset_tens_q, preset_units_q};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pre_q          <= '0;
      preset_tens_q  <= BCD_ZERO;
      preset_units_q <= BCD_ZERO;
      tens           <= BCD_ZERO;
      units          <= BCD_ZERO;
      running        <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        tens           <= bcd_clamp(load_tens);
        units          <= bcd_clamp(load_units);
        preset_tens_q  <= bcd_clamp(load_tens);
        preset_units_q <= bcd_clamp(load_units);
        pre_q          <= '0;
        state_q        <= ST_IDLE;
        running        <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !pause) begin
              pre_q <= '0;
              if (value_zero) begin
                state_q <= ST_DONE;
                done    <= 1'b1;
              end else begin
                state_q <= ST_RUN;
                running <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_HOLD;
              running <= 1'b0;
            end else if (tick) begin
              pre_q <= '0;
              if (expire) begin
                done <= 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                if (!preset_zero) begin
                  tens  <= preset_tens_q;
                  units <= preset_units_q;
                end else begin
                  tens    <= BCD_ZERO;
                  units   <= BCD_ZERO;
                  state_q <= ST_DONE;
                  running <= 1'b0;
                end
`else
                tens    <= BCD_ZERO;
                units   <= BCD_ZERO;
                state_q <= ST_DONE;
                running <= 1'b0;
`endif
              end else begin
                tens  <= next_tens;
                units <= next_units;
              end
            end else begin
              pre_q <= pre_q + PRE_W'(1);
            end
          end
          ST_HOLD: begin
            // Prescaler keeps its frozen value so the partial tick is not lost.
            if (start && !pause) begin
              state_q <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_DONE: begin
            // Only load or reset leave DONE.
          end
          default: begin
            state_q <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer using a decimal behavioural model.
module tb_bcd_countdown_timer;

  localparam int unsigned TickDiv = 4;

  logic       clock = 1'b0;
  logic       reset, load, start, pause;
  logic [3:0] load_tens, load_units;
  logic [3:0] tens, units;
  logic       running, done;

  always #5 clock = ~clock;

  bcd_countdown_timer #(
    .TICK_DIV (TickDiv),
    .PRE_W    (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_tens  (load_tens),
    .load_units (load_units),
    .start      (start),
    .pause      (pause),
    .tens       (tens),
    .units      (units),
    .running    (running),
    .done       (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: value as a plain integer 0..99, cycles elapsed in current tick.
  localparam int MIdle = 0, MRun = 1, MHold = 2, MDone = 3;
  int m_val = 0, m_pre = 0, m_preset = 0, m_mode = MIdle;
  bit m_done = 1'b0;

  function automatic logic [9:0] model_vec();
    logic [3:0] t, u;
    t = 4'(m_val / 10);
    u = 4'(m_val % 10);
    return {t, u, (m_mode == MRun), m_done};
  endfunction

  function automatic int clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_step(input bit r, input bit l, input logic [3:0] lt,
                            input logic [3:0] lu, input bit s, input bit p);
    if (r) begin
      m_val = 0; m_pre = 0; m_preset = 0; m_mode = MIdle; m_done = 0;
    end else if (l) begin
      m_preset = clamp9(lt) * 10 + clamp9(lu);
      m_val = m_preset; m_pre = 0; m_mode = MIdle; m_done = 0;
    end else begin
      m_done = 0;
      if (m_mode == MIdle) begin
        if (s && !p) begin
          m_pre = 0;
          if (m_val == 0) begin m_mode = MDone; m_done = 1; end
          else m_mode = MRun;
        end
      end else if (m_mode == MRun) begin
        if (p) m_mode = MHold;
        else if (m_pre == TickDiv - 1) begin
          m_pre = 0;
          m_val = m_val - 1;
          if (m_val == 0) begin
            m_done = 1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            if (m_preset != 0) m_val = m_preset;
            else m_mode = MDone;
`else
            m_mode = MDone;
`endif
          end
        end else m_pre = m_pre + 1;
      end else if (m_mode == MHold) begin
        if (s && !p) m_mode = MRun;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit l, input logic [3:0] lt, input logic [3:0] lu,
                       input bit s, input bit p);
    reset = r; load = l; load_tens = lt; load_units = lu; start = s; pause = p;
    @(posedge clock);
    #1;
    model_step(r, l, lt, lu, s, p);
  endtask

  task automatic test_reset();
    cycle(1, 0, 4'd0, 4'd0, 0, 0);
    cycle(1, 1, 4'd5, 4'd5, 1, 0);
    n_checks++;
    if ({tens, units, running, done} !== 10'h000)
      $display("FAIL reset_state: got %h want %h", {tens, units, running, done}, 10'h000);
    else n_pass++;
  endtask

  task automatic test_count12();
    int pulses = 0;
    cycle(0, 1, 4'd1, 4'd2, 0, 0);
    n_checks++;
    if ({tens, units} !== 8'h12)
      $display("FAIL load12: got %h want %h", {tens, units}, 8'h12);
    else n_pass++;
    cycle(0, 0, 4'd0, 4'd0, 1, 0);
    for (int i = 1; i <= 52; i++) begin
      cycle(0, 0, 4'd0, 4'd0, 0, 0);
      if (done) pulses++;
      n_checks++;
      if ({tens, units, running, done} !== model_vec())
        $display("FAIL count12_model cyc %0d: got %h want %h", i,
                 {tens, units, running, done}, model_vec());
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if ({tens, units, running} !== 9'h11_1 >> 0 && {tens, units} !== 8'h11)
          $display("FAIL count12_first: got %h want %h", {tens, units}, 8'h11);
        else n_pass++;
      end
      if (i == 12) begin
        n_checks++;
        if ({tens, units} !== 8'h09)
          $display("FAIL count12_wrap: got %h want %h", {tens, units}, 8'h09);
        else n_pass++;
      end
      if (i == 48) begin
        n_checks++;
        if ({tens, units, done} !== 9'b0000_0000_1)
          $display("FAIL count12_expire: got %h want %h", {tens, units, done}, 9'h001);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 1 || running !== 1'b0)
      $display("FAIL count12_pulses: got %0d/%b want 1/0", pulses, running);
    else n_pass++;
  endtask

  task automatic test_clamp();
    cycle(0, 1, 4'hC, 4'hF, 0, 0);
    n_checks++;
    if ({tens, units} !== 8'h99)
      $display("FAIL clamp_load: got %h want %h", {tens, units}, 8'h99);
    else n_pass++;
    cycle(0, 0, 4'd0, 4'd0, 1, 0);
    repeat (4 * TickDiv) cycle(0, 0, 4'd0, 4'd0, 0, 0);
    n_checks++;
    if ({tens, units, running} !== {8'h95, 1'b1})
      $display("FAIL clamp_run: got %h want %h", {tens, units, running}, {8'h95, 1'b1});
    else n_pass++;
  endtask

  task automatic test_pause_resume();
    cycle(0, 1, 4'd0, 4'd5, 0, 0);
    cycle(0, 0, 4'd0, 4'd0, 1, 0);
    repeat (6) cycle(0, 0, 4'd0, 4'd0, 0, 0);
    cycle(0, 0, 4'd0, 4'd0, 1, 1);  // pause beats start
    repeat (20) cycle(0, 0, 4'd0, 4'd0, 0, 0);
    n_checks++;
    if ({tens, units, running} !== {8'h04, 1'b0})
      $display("FAIL pause_hold: got %h want %h", {tens, units, running}, {8'h04, 1'b0});
    else n_pass++;
    cycle(0, 0, 4'd0, 4'd0, 1, 0);
    cycle(0, 0, 4'd0, 4'd0, 0, 0);
    n_checks++;
    if ({tens, units, running} !== {8'h04, 1'b1})
      $display("FAIL resume_early: got %h want %h", {tens, units, running}, {8'h04, 1'b1});
    else n_pass++;
    cycle(0, 0, 4'd0, 4'd0, 0, 0);
    n_checks++;
    if ({tens, units} !== 8'h03 || {tens, units, running, done} !== model_vec())
      $display("FAIL resume_dec: got %h want %h", {tens, units}, 8'h03);
    else n_pass++;
  endtask

  task automatic test_zero_start();
    cycle(1, 0, 4'd0, 4'd0, 0, 0);
    cycle(0, 0, 4'd0, 4'd0, 1, 0);
    n_checks++;
    if ({tens, units, running, done} !== 10'h001)
      $display("FAIL zero_start: got %h want %h", {tens, units, running, done}, 10'h001);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 4'd0, 4'd0, 0, 0);
      cycle(0, 0, 4'd0, 4'd0, 1, 0);
      n_checks++;
      if ({tens, units, running, done} !== 10'h000)
        $display("FAIL zero_restart %0d: got %h want %h", i,
                 {tens, units, running, done}, 10'h000);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 4'd0, 4'd3, 0, 0);
    cycle(0, 0, 4'd0, 4'd0, 1, 0);
    repeat (5) cycle(0, 0, 4'd0, 4'd0, 0, 0);
    cycle(1, 0, 4'd0, 4'd0, 0, 0);
    n_checks++;
    if ({tens, units, running, done} !== 10'h000)
      $display("FAIL reset_mid: got %h want %h", {tens, units, running, done}, 10'h000);
    else n_pass++;
  endtask

  task automatic test_load_terminal();
    cycle(0, 1, 4'd0, 4'd5, 0, 0);
    cycle(0, 0, 4'd0, 4'd0, 1, 0);
    repeat (TickDiv - 1) cycle(0, 0, 4'd0, 4'd0, 0, 0);
    n_checks++;
    if ({tens, units, running} !== {8'h05, 1'b1})
      $display("FAIL term_pre: got %h want %h", {tens, units, running}, {8'h05, 1'b1});
    else n_pass++;
    cycle(0, 1, 4'd0, 4'd7, 0, 0);
    n_checks++;
    if ({tens, units, running, done} !== {8'h07, 2'b00})
      $display("FAIL term_load: got %h want %h", {tens, units, running, done}, {8'h07, 2'b00});
    else n_pass++;
  endtask

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    cycle(0, 1, 4'd0, 4'd2, 0, 0);
    cycle(0, 0, 4'd0, 4'd0, 1, 0);
    for (int i = 1; i <= 17; i++) begin
      cycle(0, 0, 4'd0, 4'd0, 0, 0);
      n_checks++;
      if ((i == 8 || i == 16) ? ({tens, units, running, done} !== {8'h02, 2'b11})
                              : (running !== 1'b1 || done !== 1'b0))
        $display("FAIL auto_reload cyc %0d: got %h", i, {tens, units, running, done});
      else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    bit r, l, s, p;
    logic [3:0] lt, lu;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      l  = ($urandom_range(0, 19) == 0);
      lt = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 1)) : 4'($urandom);
      lu = 4'($urandom);
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 9) == 0);
      cycle(r, l, lt, lu, s, p);
      n_checks++;
      if ({tens, units, running, done} !== model_vec())
        $display("FAIL random cyc %0d: got %h want %h", i,
                 {tens, units, running, done}, model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_tens = 4'd0; load_units = 4'd0;
    start = 1'b0; pause = 1'b0;
    test_reset();
    test_count12();
    test_clamp();
    test_pause_resume();
    test_zero_start();
    test_reset_mid();
    test_load_terminal();
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    cycle(1, 0, 4'd0, 4'd0, 0, 0);
    test_auto_reload();
`endif
    cycle(1, 0, 4'd0, 4'd0, 0, 0);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
